// File: rtl/key_event_led.sv
// Key gesture classifier: short press, double click and long press pulses that drive a 4-bit LED register.
// Optional macro KEY_LONG_REPEAT_EN: auto-repeat short pulses every REPEAT_MS while a long press is held.
module key_event_led #(
   parameter int MS_CYCLES = 200000,
   parameter int LONG_MS   = 1000,
   parameter int GAP_MS    = 300,
   parameter int REPEAT_MS = 200
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       key_db,
   output logic       short_pulse,
   output logic       double_pulse,
   output logic       long_pulse,
   output logic [3:0] led
);

   localparam int MS_MAX = (LONG_MS > GAP_MS) ?
                           ((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS) :
                           ((GAP_MS > REPEAT_MS) ? GAP_MS : REPEAT_MS);
   localparam int MS_W   = $clog2(MS_MAX + 1);
   localparam int PRE_W  = $clog2(MS_CYCLES + 1);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_CYCLES - 1);
   localparam logic [MS_W-1:0]  MS_SAT   = MS_W'(MS_MAX);
   localparam logic [MS_W-1:0]  MS_LONG  = MS_W'(LONG_MS);
   localparam logic [MS_W-1:0]  MS_GAP   = MS_W'(GAP_MS);
`ifdef KEY_LONG_REPEAT_EN
   localparam logic [MS_W-1:0]  MS_REP_LAST = MS_W'(REPEAT_MS - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS1,
      S_WAIT2,
      S_PRESS2,
      S_LONG_HOLD
   } state_t;

   state_t           r_state;
   logic             r_key_q;
   logic [PRE_W-1:0] r_pre;
   logic [MS_W-1:0]  r_ms;
   logic             r_short;
   logic             r_double;
   logic             r_long;
   logic [3:0]       r_led;

   logic w_press;
   logic w_release;
   logic w_ms_tick;

   assign w_press   = r_key_q & ~key_db;
   assign w_release = ~r_key_q & key_db;
   assign w_ms_tick = (r_pre == PRE_LAST);

   // Later assignments to r_pre/r_ms override the free-running timebase so
   // every state transition restarts timing from zero.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_key_q  <= 1'b0;
         r_pre    <= '0;
         r_ms     <= '0;
         r_short  <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;
         r_led    <= 4'h0;
      end else begin
         r_key_q  <= key_db;
         r_short  <= 1'b0;
         r_double <= 1'b0;
         r_long   <= 1'b0;

         if (w_ms_tick) begin
            r_pre <= '0;
            if (r_ms != MS_SAT) r_ms <= r_ms + 1'b1;
         end else begin
            r_pre <= r_pre + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_press) begin
                  r_state <= S_PRESS1;
                  r_pre   <= '0;
                  r_ms    <= '0;
               end
            end
            S_PRESS1: begin
               // Threshold wins over a simultaneous release.
               if (r_ms >= MS_LONG) begin
                  r_long  <= 1'b1;
                  r_led   <= 4'h0;
                  r_state <= S_LONG_HOLD;
                  r_pre   <= '0;
                  r_ms    <= '0;
               end else if (w_release) begin
                  r_state <= S_WAIT2;
                  r_pre   <= '0;
                  r_ms    <= '0;
               end
            end
            S_WAIT2: begin
               // Timeout wins over a simultaneous press.
               if (r_ms >= MS_GAP) begin
                  r_short <= 1'b1;
                  r_led   <= r_led + 4'd1;
                  r_state <= S_IDLE;
                  r_pre   <= '0;
                  r_ms    <= '0;
               end else if (w_press) begin
                  r_state <= S_PRESS2;
                  r_pre   <= '0;
                  r_ms    <= '0;
               end
            end
            S_PRESS2: begin
               if (w_release) begin
                  r_double <= 1'b1;
                  r_led    <= ~r_led;
                  r_state  <= S_IDLE;
                  r_pre    <= '0;
                  r_ms     <= '0;
               end
            end
            S_LONG_HOLD: begin
               // Level check: the release may already have happened on the threshold cycle.
               if (key_db) begin
                  r_state <= S_IDLE;
                  r_pre   <= '0;
                  r_ms    <= '0;
               end
`ifdef KEY_LONG_REPEAT_EN
               else if (w_ms_tick && (r_ms == MS_REP_LAST)) begin
                  r_short <= 1'b1;
                  r_led   <= r_led + 4'd1;
                  r_pre   <= '0;
                  r_ms    <= '0;
               end
`endif
            end
            default: begin
               r_state <= S_IDLE;
               r_pre   <= '0;
               r_ms    <= '0;
            end
         endcase
      end
   end

   assign short_pulse  = r_short;
   assign double_pulse = r_double;
   assign long_pulse   = r_long;
   assign led          = r_led;

endmodule

// File: tb/tb_key_event_led.sv
// Scoreboard bench for key_event_led: directed gestures push expected pulses, a monitor pops and compares them.
module tb_key_event_led;

   localparam int MS_CYCLES = 10;
   localparam int LONG_MS   = 20;
   localparam int GAP_MS    = 5;
   localparam int REPEAT_MS = 4;
   localparam int T_LONG    = LONG_MS * MS_CYCLES + 1;  // 201
   localparam int T_SHORT   = GAP_MS * MS_CYCLES + 1;   // 51
   localparam int T_REP     = REPEAT_MS * MS_CYCLES;    // 40

   localparam logic [2:0] K_SHORT  = 3'b001;
   localparam logic [2:0] K_DOUBLE = 3'b010;
   localparam logic [2:0] K_LONG   = 3'b100;

   logic       sys_clk = 1'b0;
   logic       rst_n   = 1'b0;
   logic       key_db  = 1'b1;
   logic       short_pulse;
   logic       double_pulse;
   logic       long_pulse;
   logic [3:0] led;

   key_event_led #(
      .MS_CYCLES(MS_CYCLES),
      .LONG_MS  (LONG_MS),
      .GAP_MS   (GAP_MS),
      .REPEAT_MS(REPEAT_MS)
   ) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .key_db      (key_db),
      .short_pulse (short_pulse),
      .double_pulse(double_pulse),
      .long_pulse  (long_pulse),
      .led         (led)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] kind;
      int         at;
      logic [3:0] led;
   } exp_t;

   exp_t       q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   logic [3:0] m_led  = 4'h0;
   bit         mon_en = 1'b0;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic expect_ev(input logic [2:0] k, input int at);
      exp_t e;
      case (k)
         K_SHORT:  m_led = m_led + 4'd1;
         K_DOUBLE: m_led = ~m_led;
         default:  m_led = 4'h0;
      endcase
      e.kind = k;
      e.at   = at;
      e.led  = m_led;
      q.push_back(e);
   endtask

   // Low for 'low' edges, then high for 'high' edges; reports the sampling edges.
   task automatic gesture(input int low, input int high, output int p_edge, output int r_edge);
      p_edge = cyc + 1;
      key_db = 1'b0;
      step(low);
      r_edge = cyc + 1;
      key_db = 1'b1;
      step(high);
   endtask

   always @(negedge sys_clk) begin : monitor
      exp_t e;
      if (mon_en && (short_pulse || double_pulse || long_pulse)) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", int'({long_pulse, double_pulse, short_pulse}), 0);
         end else begin
            e = q.pop_front();
            check("pulse_kind", int'({long_pulse, double_pulse, short_pulse}), int'(e.kind));
            check("pulse_cycle", cyc, e.at);
            check("pulse_led", int'(led), int'(e.led));
         end
      end
   end

   initial begin
      int p, r;
      rst_n  = 1'b0;
      key_db = 1'b1;
      step(3);
      check("rst_led", int'(led), 0);
      check("rst_pulses", int'({long_pulse, double_pulse, short_pulse}), 0);
      rst_n = 1'b1;
      step(2);
      mon_en = 1'b1;

      // Short press: 50 cycles low.
      gesture(50, 0, p, r);
      expect_ev(K_SHORT, r + T_SHORT);
      step(60);

      // Double click: 30 low, 20 gap, 30 low.
      gesture(30, 20, p, r);
      gesture(30, 0, p, r);
      expect_ev(K_DOUBLE, r);
      step(60);

      // Long press held for 300 cycles.
      p = cyc + 1;
      expect_ev(K_LONG, p + T_LONG);
`ifdef KEY_LONG_REPEAT_EN
      expect_ev(K_SHORT, p + T_LONG + T_REP);
      expect_ev(K_SHORT, p + T_LONG + 2 * T_REP);
`endif
      key_db = 1'b0;
      step(300);
      key_db = 1'b1;
      step(30);

      // Sixteen short presses wrap the LED counter back to its start value.
      for (int i = 0; i < 16; i++) begin
         gesture(10, 0, p, r);
         expect_ev(K_SHORT, r + T_SHORT);
         step(60);
      end

      // Reset 10 cycles into the gap, key held low through reset release.
      gesture(30, 10, p, r);
      key_db = 1'b0;
      rst_n  = 1'b0;
      step(3);
      m_led = 4'h0;
      check("abort_led", int'(led), 0);
      rst_n = 1'b1;
      step(300);
      key_db = 1'b1;
      step(60);
      gesture(10, 0, p, r);
      expect_ev(K_SHORT, r + T_SHORT);
      step(60);

      // Second press on the exact timeout cycle: short only, press ignored.
      gesture(10, 0, p, r);
      expect_ev(K_SHORT, r + T_SHORT);
      step(T_SHORT);
      key_db = 1'b0;
      step(30);
      key_db = 1'b1;
      step(60);

      // Second press one cycle before the timeout: double click.
      gesture(10, 0, p, r);
      step(T_SHORT - 1);
      gesture(30, 0, p, r);
      expect_ev(K_DOUBLE, r);
      step(60);

      // Release on the same edge the long threshold is reached: long wins.
      p = cyc + 1;
      expect_ev(K_LONG, p + T_LONG);
      key_db = 1'b0;
      step(T_LONG);
      key_db = 1'b1;
      step(60);
      gesture(10, 0, p, r);
      expect_ev(K_SHORT, r + T_SHORT);
      step(60);

      check("pending_expected", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
